sipo_deserializer: RTL and testbench

Serial-in, parallel-out receiver: the capture end of the single-bit D-input streams that our flip-flop benches drive one bit per clock. Accepts one qualified bit per cycle, assembles MSB-first words of `WIDTH` bits and presents each word through a one-entry valid/ready holding register. Sits between a serial bit source (bench driver, synchronizer output or shift chain) and any parallel consumer.

---
 rtl/sipo_deserializer.sv | 134 +++++++++++++
 tb/tb_sipo_deserializer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: MSB-first WIDTH-bit words into a one-entry valid/ready holding register.
// Optional even-parity frame bit enabled by defining SIPO_PARITY_EN.
module sipo_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             d_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             parity_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

`ifdef SIPO_PARITY_EN
    // The full data word must sit in sr while the parity bit is awaited.
    localparam int SRW = WIDTH;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
    // The last data bit completes the word straight from the input, so sr never needs the top bit.
    localparam int SRW = WIDTH - 1;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [SRW-1:0]   sr, sr_n;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             done;

`ifdef SIPO_PARITY_EN
    logic             word_perr;
    logic             perr_q;
    assign shifted    = {sr[WIDTH-2:0], d};
    assign parity_err = perr_q;
`else
    assign shifted    = {sr, d};
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        word    = '0;
        done    = 1'b0;
`ifdef SIPO_PARITY_EN
        word_perr = 1'b0;
`endif
        if (frame_sync) begin
            sr_n    = '0;
            cnt_n   = '0;
            state_n = IDLE;
            if (d_valid) begin
                sr_n[0] = d;
                cnt_n   = CW'(1);
                state_n = SHIFT;
            end
        end else if (d_valid) begin
            case (state)
                IDLE: begin
                    sr_n    = shifted[SRW-1:0];
                    cnt_n   = CW'(1);
                    state_n = SHIFT;
                end
                SHIFT: begin
                    sr_n = shifted[SRW-1:0];
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt_n = '0;
`ifdef SIPO_PARITY_EN
                        state_n = PAR;
`else
                        done    = 1'b1;
                        word    = shifted;
                        state_n = IDLE;
`endif
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
`ifdef SIPO_PARITY_EN
                PAR: begin
                    done      = 1'b1;
                    word      = sr;
                    word_perr = ^{sr, d};
                    state_n   = IDLE;
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sr    <= sr_n;
            // A completing word may replace one that is being drained in the same cycle.
            if (done && (!out_valid || out_ready)) begin
                out_data  <= word;
                out_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
                perr_q    <= word_perr;
`endif
            end else begin
                if (done)
                    overrun <= 1'b1;
                if (out_valid && out_ready)
                    out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed table, hand sequences, and random traffic
// against a queue-based frame model.
module tb_sipo_deserializer;

    localparam int W = 8;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         d = 1'b0;
    logic         d_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         parity_err;
    logic         overrun;
    logic         busy;

    int checks = 0;
    int errors = 0;

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .frame_sync(frame_sync),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .parity_err(parity_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: bits of the current frame in a queue, plus the held word.
    bit           q_bits[$];
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    logic         m_perr = 1'b0;
    logic         m_ovr = 1'b0;

    task automatic model_update();
        bit [W-1:0] w;
        bit         p;
        bit         done;
        w = '0;
        p = 1'b0;
        done = 1'b0;
        if (!rst) begin
            q_bits.delete();
            m_valid = 1'b0; m_data = '0; m_perr = 1'b0; m_ovr = 1'b0;
        end else begin
            if (frame_sync) begin
                q_bits.delete();
                if (d_valid) q_bits.push_back(d);
            end else if (d_valid) begin
                q_bits.push_back(d);
                if (q_bits.size() == FRAME) begin
                    done = 1'b1;
                    for (int i = 0; i < W; i++) w = {w[W-2:0], q_bits[i]};
                    for (int i = 0; i < FRAME; i++) p ^= q_bits[i];
                    q_bits.delete();
                end
            end
            if (done) begin
                if (!m_valid || out_ready) begin
                    m_valid = 1'b1;
                    m_data  = w;
                    m_perr  = (FRAME > W) ? p : 1'b0;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, " busy"}, 32'(busy), 32'(q_bits.size() != 0));
        chk({tag, " overrun"}, 32'(overrun), 32'(m_ovr));
        if (m_valid) begin
            chk({tag, " out_data"}, 32'(out_data), 32'(m_data));
            chk({tag, " parity_err"}, 32'(parity_err), 32'(m_perr));
        end
    endtask

    task automatic send_word(input logic [7:0] w, input logic pb);
        for (int i = 7; i >= 0; i--) begin
            d_valid = 1'b1; d = w[i];
            step();
        end
        if (FRAME > W) begin
            d_valid = 1'b1; d = pb;
            step();
        end
        d_valid = 1'b0;
    endtask

    typedef struct {
        logic       dv, dd, fs, rdy;
        logic       ev;
        logic [7:0] ed;
        logic       ep, eb, eo;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic dv, dd, fs, rdy, ev, input logic [7:0] ed,
                       input logic ep, eb, eo);
        vec_t v;
        v.dv = dv; v.dd = dd; v.fs = fs; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.ep = ep; v.eb = eb; v.eo = eo;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] b;
        logic       last;
        b = 8'hB2;

        // Reset held two cycles with traffic on the input
        rst = 1'b0; d_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d = 1'($urandom);
            step();
            chk("rst out_data", 32'(out_data), 0);
            chk("rst out_valid", 32'(out_valid), 0);
            chk("rst parity_err", 32'(parity_err), 0);
            chk("rst overrun", 32'(overrun), 0);
            chk("rst busy", 32'(busy), 0);
        end
        rst = 1'b1; d_valid = 1'b0;
        step();
        chk("post-rst busy", 32'(busy), 0);
        chk("post-rst out_valid", 32'(out_valid), 0);

        // Single word, consecutive bits (B2 has even weight -> parity bit 0)
        for (int i = 0; i < FRAME; i++) begin
            last = (i == FRAME - 1);
            add(1'b1, (i < W) ? b[7-i] : 1'b0, 1'b0, 1'b1, last, 8'hB2, 1'b0, !last, 1'b0);
        end
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // Same word with idle gaps between bits
        for (int i = 0; i < FRAME; i++) begin
            last = (i == FRAME - 1);
            add(1'b1, (i < W) ? b[7-i] : 1'b0, 1'b0, 1'b1, last, 8'hB2, 1'b0, !last, 1'b0);
            if (!last) add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // Resync: 3 bits, then sync with bit 0 = 0, then seven ones -> 7F (odd weight -> parity bit 1)
        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < FRAME; i++) begin
            last = (i == FRAME - 1);
            add(1'b1, 1'b1, 1'b0, 1'b1, last, 8'h7F, 1'b0, !last, 1'b0);
        end
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // Sync without a bit returns to idle
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        foreach (tbl[k]) begin
            d_valid = tbl[k].dv; d = tbl[k].dd; frame_sync = tbl[k].fs; out_ready = tbl[k].rdy;
            step();
            chk($sformatf("tbl[%0d] out_valid", k), 32'(out_valid), 32'(tbl[k].ev));
            chk($sformatf("tbl[%0d] busy", k), 32'(busy), 32'(tbl[k].eb));
            chk($sformatf("tbl[%0d] overrun", k), 32'(overrun), 32'(tbl[k].eo));
            if (tbl[k].ev) begin
                chk($sformatf("tbl[%0d] out_data", k), 32'(out_data), 32'(tbl[k].ed));
                chk($sformatf("tbl[%0d] parity_err", k), 32'(parity_err), 32'(tbl[k].ep));
            end
        end
        frame_sync = 1'b0; d_valid = 1'b0;

        // Backpressure: second word is dropped and overrun sticks
        out_ready = 1'b0;
        send_word(8'hB2, 1'b0);
        chk("bp first valid", 32'(out_valid), 1);
        chk("bp first data", 32'(out_data), 32'hB2);
        chk("bp first overrun", 32'(overrun), 0);
        send_word(8'h5A, 1'b0);
        chk("bp held data", 32'(out_data), 32'hB2);
        chk("bp held valid", 32'(out_valid), 1);
        chk("bp overrun", 32'(overrun), 1);
        out_ready = 1'b1;
        step();
        chk("bp drained valid", 32'(out_valid), 0);
        chk("bp overrun sticky", 32'(overrun), 1);

        // Reset mid-word while a word is held
        out_ready = 1'b0;
        send_word(8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            d_valid = 1'b1; d = 1'b1;
            step();
        end
        chk("midrst busy before", 32'(busy), 1);
        rst = 1'b0; d_valid = 1'b0;
        step();
        chk("midrst valid", 32'(out_valid), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst overrun", 32'(overrun), 0);
        chk("midrst data", 32'(out_data), 0);
        rst = 1'b1;
        step();

`ifdef SIPO_PARITY_EN
        out_ready = 1'b1;
        send_word(8'hB2, 1'b0);
        chk("par good valid", 32'(out_valid), 1);
        chk("par good err", 32'(parity_err), 0);
        step();
        send_word(8'hB2, 1'b1);
        chk("par bad valid", 32'(out_valid), 1);
        chk("par bad err", 32'(parity_err), 1);
        chk("par bad data", 32'(out_data), 32'hB2);
        step();
`endif

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 299) != 0);
            d_valid    = ($urandom_range(0, 3) != 0);
            d          = 1'($urandom);
            frame_sync = ($urandom_range(0, 39) == 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            step();
            chk_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
